// File: rtl/mul_share_arb.sv
// Round-robin arbiter sharing one pipelined WxW unsigned multiplier among NREQ requesters.
// Optional completed-operation counter on stat_ops when MUL_SHARE_ARB_STATS_EN is defined.
module mul_share_arb #(
  parameter int NREQ    = 4,
  parameter int W       = 16,
  parameter int MUL_LAT = 3,
  parameter int IDW     = 3
) (
  input  logic                clk100,
  input  logic                reset,
  input  logic                locked,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [2*W-1:0]      rsp_data,
  output logic                busy,
  output logic [31:0]         stat_ops
);

  localparam int PW = 2 * W;

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic           accept;
  logic [IDW-1:0] gnt_id;
  logic [W-1:0]   sel_a, sel_b;

  logic           vld0_q, vld0_d;
  logic [IDW-1:0] id0_q, id0_d;
  logic [W-1:0]   a0_q, a0_d, b0_q, b0_d;
  logic           busy_q, busy_d;
  logic           tail_busy_d;

  // Two passes: indices at or above the pointer first, then the wrapped-around ones.
  // NOTE: always_comb uses blocking '=' so 'accept' set by an earlier iteration is
  // visible to later ones; every output gets a default first so no latch is inferred.
  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    gnt_id    = '0;
    sel_a     = '0;
    sel_b     = '0;
    if (!reset && locked) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!accept && req_valid[j] && (IDW'(j) >= rr_ptr_q)) begin
          accept       = 1'b1;
          req_ready[j] = 1'b1;
          gnt_id       = IDW'(j);
          sel_a        = req_a[j*W +: W];
          sel_b        = req_b[j*W +: W];
        end
      end
      for (int j = 0; j < NREQ; j++) begin
        if (!accept && req_valid[j]) begin
          accept       = 1'b1;
          req_ready[j] = 1'b1;
          gnt_id       = IDW'(j);
          sel_a        = req_a[j*W +: W];
          sel_b        = req_b[j*W +: W];
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    vld0_d   = accept;
    id0_d    = id0_q;
    a0_d     = a0_q;
    b0_d     = b0_q;
    if (accept) begin
      rr_ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
      id0_d    = gnt_id;
      a0_d     = sel_a;
      b0_d     = sel_b;
    end
    busy_d = vld0_d | tail_busy_d;
  end

  // NOTE: payload registers are reset too (not just valids) because rsp_id/rsp_data
  // must read zero after reset and otherwise only change on a valid operation.
  always_ff @(posedge clk100) begin
    if (reset) begin
      rr_ptr_q <= '0;
      vld0_q   <= 1'b0;
      id0_q    <= '0;
      a0_q     <= '0;
      b0_q     <= '0;
      busy_q   <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      vld0_q   <= vld0_d;
      id0_q    <= id0_d;
      a0_q     <= a0_d;
      b0_q     <= b0_d;
      busy_q   <= busy_d;
    end
  end

  assign busy = busy_q;

  generate
    if (MUL_LAT == 1) begin : g_lat1
      assign tail_busy_d = 1'b0;
      assign rsp_valid   = vld0_q;
      assign rsp_id      = id0_q;
      assign rsp_data    = PW'(a0_q) * PW'(b0_q);
    end else begin : g_latn
      logic [MUL_LAT-1:1] vld_q, vld_d;
      logic [IDW-1:0]     id_q   [MUL_LAT-1:1];
      logic [IDW-1:0]     id_d   [MUL_LAT-1:1];
      logic [PW-1:0]      prod_q [MUL_LAT-1:1];
      logic [PW-1:0]      prod_d [MUL_LAT-1:1];

      // Payload only advances with a valid op, so the last stage holds the last result.
      always_comb begin
        vld_d     = '0;
        id_d      = id_q;
        prod_d    = prod_q;
        vld_d[1]  = vld0_q;
        if (vld0_q) begin
          id_d[1]   = id0_q;
          prod_d[1] = PW'(a0_q) * PW'(b0_q);
        end
        for (int s = 2; s < MUL_LAT; s++) begin
          vld_d[s] = vld_q[s-1];
          if (vld_q[s-1]) begin
            id_d[s]   = id_q[s-1];
            prod_d[s] = prod_q[s-1];
          end
        end
      end

      always_ff @(posedge clk100) begin
        if (reset) begin
          vld_q <= '0;
          for (int s = 1; s < MUL_LAT; s++) begin
            id_q[s]   <= '0;
            prod_q[s] <= '0;
          end
        end else begin
          vld_q  <= vld_d;
          id_q   <= id_d;
          prod_q <= prod_d;
        end
      end

      assign tail_busy_d = |vld_d;
      assign rsp_valid   = vld_q[MUL_LAT-1];
      assign rsp_id      = id_q[MUL_LAT-1];
      assign rsp_data    = prod_q[MUL_LAT-1];
    end
  endgenerate

`ifdef MUL_SHARE_ARB_STATS_EN
  logic [31:0] stat_ops_q, stat_ops_d;

  always_comb begin
    stat_ops_d = stat_ops_q;
    if (rsp_valid) stat_ops_d = stat_ops_q + 32'd1;
  end

  always_ff @(posedge clk100) begin
    if (reset) stat_ops_q <= '0;
    else       stat_ops_q <= stat_ops_d;
  end

  assign stat_ops = stat_ops_q;
`else
  assign stat_ops = 32'h0;
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// Self-checking bench for mul_share_arb: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue-based reference model.
module tb_mul_share_arb;

  localparam int NREQ    = 4;
  localparam int W       = 16;
  localparam int MUL_LAT = 3;
  localparam int IDW     = 3;

  logic                clk100 = 1'b0;
  logic                reset;
  logic                locked;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*W-1:0]   req_a, req_b;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [2*W-1:0]      rsp_data;
  logic                busy;
  logic [31:0]         stat_ops;

  mul_share_arb #(.NREQ(NREQ), .W(W), .MUL_LAT(MUL_LAT), .IDW(IDW)) dut (
    .clk100(clk100), .reset(reset), .locked(locked),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .stat_ops(stat_ops)
  );

  always #5 clk100 = ~clk100;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        pend[$];
  int          cyc      = 0;
  bit          model_ok = 0;
  int          m_rr     = 0;
  logic [31:0] m_last_data = '0;
  int          m_last_id   = 0;
  logic [31:0] m_ops       = '0;

  always @(negedge clk100) begin
    int          k;
    logic [NREQ-1:0] exp_ready;
    logic [31:0] exp_stat;
    cyc++;
    k = -1;
    exp_ready = '0;
    if (!reset && locked)
      for (int i = 0; i < NREQ; i++)
        if (k < 0 && req_valid[(m_rr + i) % NREQ]) k = (m_rr + i) % NREQ;
    if (k >= 0) exp_ready[k] = 1'b1;

    if (model_ok) begin
`ifdef MUL_SHARE_ARB_STATS_EN
      exp_stat = m_ops;
`else
      exp_stat = 32'h0;
`endif
      check("req_ready", req_ready, exp_ready);
      check("busy", busy, pend.size() > 0);
      check("stat_ops", stat_ops, exp_stat);
      if (pend.size() > 0 && pend[0].due == cyc) begin
        check("rsp_valid", rsp_valid, 1'b1);
        check("rsp_id", rsp_id, pend[0].id);
        check("rsp_data", rsp_data, pend[0].data);
        m_last_id   = pend[0].id;
        m_last_data = pend[0].data;
        m_ops       = m_ops + 32'd1;
        void'(pend.pop_front());
      end else begin
        check("rsp_valid_idle", rsp_valid, 1'b0);
        check("rsp_id_hold", rsp_id, m_last_id);
        check("rsp_data_hold", rsp_data, m_last_data);
      end
    end

    if (reset) begin
      pend.delete();
      m_rr        = 0;
      m_last_id   = 0;
      m_last_data = '0;
      m_ops       = '0;
      model_ok    = 1;
    end else if (k >= 0) begin
      exp_t e;
      e.id   = k;
      e.data = 32'(req_a[k*W +: W]) * 32'(req_b[k*W +: W]);
      e.due  = cyc + MUL_LAT;
      pend.push_back(e);
      m_rr = (k + 1) % NREQ;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  int rsp_seen;

  initial begin
    reset = 1'b1; locked = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Single request on requester 2
    set_op(2, 16'h0003, 16'h0005);
    req_valid = 4'b0100;
    @(negedge clk100);
    check("single_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    tick();
    @(negedge clk100);
    check("single_busy_mid", busy, 1'b1);
    tick();
    @(negedge clk100);
    check("single_rsp_valid", rsp_valid, 1'b1);
    check("single_rsp_id", rsp_id, 3'd2);
    check("single_rsp_data", rsp_data, 32'h0000_000F);
    repeat (4) tick();

    // Full contention from a fresh reset
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, W'(i + 1), 16'h0010);
    req_valid = 4'b1111;
    for (int n = 0; n < 7; n++) begin
      @(negedge clk100);
      if (n < 4) check("contend_ready", req_ready, 4'b0001 << n);
      if (n >= 3) begin
        check("contend_rsp_valid", rsp_valid, 1'b1);
        check("contend_rsp_id", rsp_id, n - 3);
        check("contend_rsp_data", rsp_data, 32'((n - 2) * 16));
      end
      tick();
      if (n == 3) req_valid = '0;
    end
    @(negedge clk100);
`ifdef MUL_SHARE_ARB_STATS_EN
    check("contend_stat_ops", stat_ops, 32'd4);
`endif
    tick();

    // Rotation skip: move pointer to 1, then present 1001
    set_op(0, 16'h0007, 16'h0009);
    req_valid = 4'b0001;
    @(negedge clk100); check("skip_setup", req_ready, 4'b0001);
    tick();
    req_valid = 4'b1001;
    @(negedge clk100); check("skip_first", req_ready, 4'b1000);
    tick();
    @(negedge clk100); check("skip_second", req_ready, 4'b0001);
    tick();
    req_valid = 4'b1111;
    @(negedge clk100); check("skip_ptr_end", req_ready, 4'b0010);
    req_valid = '0;
    repeat (4) tick();

    // Operand extremes on requesters 1 and 2
    set_op(1, 16'hFFFF, 16'hFFFF);
    set_op(2, 16'h0000, 16'hFFFF);
    req_valid = 4'b0110;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk100);
      if (n == 0) check("ext_ready0", req_ready, 4'b0010);
      if (n == 1) check("ext_ready1", req_ready, 4'b0100);
      if (n == 3) check("ext_max_data", rsp_data, 32'hFFFE_0001);
      if (n == 4) begin
        check("ext_zero_id", rsp_id, 3'd2);
        check("ext_zero_data", rsp_data, 32'h0);
      end
      tick();
      if (n == 1) req_valid = '0;
    end
    tick();

    // Lock loss with two operations in flight (pointer at 3)
    req_valid = 4'b1111;
    tick(); tick();
    locked = 1'b0;
    rsp_seen = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk100);
      check("lock_ready_off", req_ready, 4'b0000);
      if (rsp_valid) rsp_seen++;
      tick();
    end
    check("lock_inflight_done", rsp_seen, 2);
    locked = 1'b1;
    @(negedge clk100); check("lock_resume", req_ready, 4'b0010);
    req_valid = '0;
    repeat (4) tick();

    // Reset with two operations in flight
    req_valid = 4'b1111;
    tick(); tick();
    req_valid = '0;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk100);
      check("rst_no_rsp", rsp_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_stat", stat_ops, 32'h0);
      tick();
    end
    req_valid = 4'b1111;
    @(negedge clk100); check("rst_ptr", req_ready, 4'b0001);
    req_valid = '0;
    tick();

    // Randomized traffic, including lock drops and occasional resets
    for (int n = 0; n < 3000; n++) begin
      reset  = ($urandom_range(0, 199) == 0);
      locked = ($urandom_range(0, 9) != 0);
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) set_op(i, rand_op(), rand_op());
      tick();
    end
    reset = 1'b0; locked = 1'b1; req_valid = '0;
    repeat (MUL_LAT + 3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Shares one fully pipelined W×W unsigned multiplier among NREQ requesters on the clk100 domain.
- Round-robin arbitration issues at most one operation per cycle.
- Each operation carries a requester-ID tag down the pipeline, so every product returns with the ID of its source.
- Arbitration is held off while the clock wizard reports not-locked, so no operation is issued on an unstable clock.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 16, operand width; product width is 2*W.
- MUL_LAT, 3, multiplier pipeline depth in cycles (1..8). The multiplier is a behavioural register pipeline inside this block.
- IDW, 3, tag width; must satisfy 2**IDW >= NREQ.

Ports:
- clk100  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- locked  in  1  clock-wizard lock; 0 blocks new grants.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  one-hot grant; combinational from req_valid, locked and the rotation pointer.
- req_a  in  NREQ*W  packed operand A; requester i occupies bits [i*W +: W].
- req_b  in  NREQ*W  packed operand B; same packing as req_a.
- rsp_valid  out  1  product valid; pulses for 1 cycle per operation.
- rsp_id  out  IDW  requester index of the product.
- rsp_data  out  2*W  unsigned product.
- busy  out  1  at least one operation in flight.
- stat_ops  out  32  completed-operation count; see Optional Feature.

Behaviour:
- Clock and reset:
  - One clock (clk100). Reset is synchronous and active-high.
  - While reset=1 at a clock edge:
    - all pipeline valid bits clear;
    - rr_ptr <= 0;
    - rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, stat_ops=0.
  - req_ready=0 whenever reset=1.
- Arbitration:
  - Search req_valid starting at index rr_ptr and wrapping modulo NREQ. The first set bit k gets req_ready[k]=1; all other bits are 0.
  - If locked=0 or no req_valid bit is set, req_ready is all zero.
  - An accept occurs when req_valid[k] & req_ready[k] at a rising edge.
  - On accept, rr_ptr <= (k+1) mod NREQ. Without an accept, rr_ptr holds.
  - A requester must hold req_valid and its operands stable until accepted. Deasserting req_valid before accept is legal and withdraws the request.
- Pipeline:
  - Stage 0 registers {valid, id=k, a, b} on accept. Stage 0 valid=0 on a cycle with no accept.
  - The product is formed across the stages. rsp_* is driven from the last stage.
  - An accept at edge t produces rsp_valid=1 on the cycle following edge t+MUL_LAT-1, i.e. MUL_LAT cycles after the accept edge.
  - Throughput is 1 operation per cycle; there are no bubbles under back-to-back grants.
  - Products are exact: a*b is computed in 2*W bits with no truncation.
- No output back-pressure: consumers must accept rsp_* in the cycle it is valid.
- rsp_id and rsp_data hold their last value when rsp_valid=0. Only rsp_valid qualifies them.
- busy = OR of all stage valid bits, registered alongside the stages.
- locked falling mid-operation:
  - new grants stop immediately (same cycle);
  - in-flight operations complete and emit normally.
- locked rising: grants resume from the current rr_ptr.
- reset mid-operation: all in-flight operations are discarded, and no rsp_valid is produced for them after reset.
- NREQ=1: the requester is granted whenever req_valid=1 and locked=1.

Optional Feature:
- Macro MUL_SHARE_ARB_STATS_EN.
- Defined: stat_ops increments by 1 on every cycle with rsp_valid=1.
  - Wraps from 0xFFFF_FFFF to 0.
  - Cleared by reset only.
- Not defined: stat_ops is tied to 32'h0 and no counter logic is synthesised.

Test Plan:
- Single request: locked=1, only req_valid[2]=1, a=0x0003, b=0x0005, MUL_LAT=3 -> req_ready=4'b0100. 3 cycles after accept: rsp_valid=1 for one cycle, rsp_id=2, rsp_data=0x0000_000F. busy is high across the interval.
- Full contention: req_valid=4'b1111 held continuously, each requester i with a=i+1, b=0x10 -> grant order 0,1,2,3,0,... one per cycle. Responses back-to-back with ids 0,1,2,3 and data 0x10,0x20,0x30,0x40.
- Rotation skip: rr_ptr=1, req_valid=4'b1001 -> grant 3 first, then 0. rr_ptr ends at 1.
- Extremes: a=0xFFFF, b=0xFFFF -> rsp_data=0xFFFE_0001. a=0, b=0xFFFF -> rsp_data=0.
- Lock loss: two ops accepted, then locked=0 for 5 cycles with all req_valid=1 -> req_ready=0 throughout. Both in-flight responses still appear. Grants resume the cycle locked returns to 1.
- Reset mid-flight: accept 2 ops, assert reset for 1 cycle before either response -> no rsp_valid afterwards, busy=0, rr_ptr=0. With MUL_SHARE_ARB_STATS_EN defined: stat_ops=0 after reset, and stat_ops=4 after the 4-op contention test.
